// File: rtl/burst_read_if.sv
// Command/status bundle between a burst command source
// and the burst read controller.
interface burst_read_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;
  logic              ws;
  logic              abort;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic              ds;
  logic              err;
  logic              busy;
  logic [LEN_W:0]    beats_ok;

  modport master (
    output start, start_addr, start_len,
    output ws, abort,
    input  rd, addr, ds, err, busy, beats_ok
  );

  modport slave (
    input  start, start_addr, start_len,
    input  ws, abort,
    output rd, addr, ds, err, busy, beats_ok
  );
endinterface

// File: rtl/burst_read_ctrl.sv
// Multi-beat read controller with wait-state retry,
// timeout, abort and registered status outputs.
module burst_read_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 4,
  parameter int WAIT_MAX = 7
) (
  input logic        clk,
  input logic        rst,
  burst_read_if.slave bus
);
  localparam int WC_W =
    (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WC_W-1:0] WMAX = WC_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DLY  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [LEN_W:0]    bok_q, bok_d;
  logic              rd_q, rd_d;
  logic              ds_q, ds_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      addr_q <= '0;
      left_q <= '0;
      wcnt_q <= '0;
      bok_q  <= '0;
      rd_q   <= 1'b0;
      ds_q   <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      left_q <= left_d;
      wcnt_q <= wcnt_d;
      bok_q  <= bok_d;
      rd_q   <= rd_d;
      ds_q   <= ds_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    st_d = IDLE;
    case (st_q)
      IDLE: st_d = bus.start ? READ : IDLE;
      READ: st_d = bus.abort ? DONE : DLY;
      DLY: begin
        if (bus.abort)
          st_d = DONE;
        else if (bus.ws)
          st_d = (wcnt_q < WMAX) ? READ : DONE;
        else
          st_d = (left_q == '0) ? DONE : READ;
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    left_d = left_q;
    wcnt_d = wcnt_q;
    bok_d  = bok_q;
    rd_d   = rd_q;
    ds_d   = 1'b0;
    err_d  = err_q;
    busy_d = busy_q;
    case (st_q)
      IDLE: begin
        rd_d   = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          addr_d = bus.start_addr;
          left_d = bus.start_len;
          wcnt_d = '0;
          bok_d  = '0;
          rd_d   = 1'b1;
          busy_d = 1'b1;
          err_d  = 1'b0;
        end
      end
      READ: begin
        if (bus.abort) begin
          ds_d  = 1'b1;
          err_d = 1'b1;
          rd_d  = 1'b0;
        end
      end
      DLY: begin
        // abort outranks ws; ws=1 retries the same beat
        if (bus.abort) begin
          ds_d  = 1'b1;
          err_d = 1'b1;
          rd_d  = 1'b0;
        end else if (bus.ws) begin
          if (wcnt_q < WMAX) begin
            wcnt_d = wcnt_q + 1'b1;
          end else begin
            ds_d  = 1'b1;
            err_d = 1'b1;
            rd_d  = 1'b0;
          end
        end else begin
          bok_d = bok_q + 1'b1;
          if (left_q == '0) begin
            ds_d  = 1'b1;
            err_d = 1'b0;
            rd_d  = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
            left_d = left_q - 1'b1;
            wcnt_d = '0;
          end
        end
      end
      DONE: begin
        rd_d   = 1'b0;
        busy_d = 1'b0;
      end
      default: begin
        addr_d = '0;
        left_d = '0;
        wcnt_d = '0;
        bok_d  = '0;
        rd_d   = 1'b0;
        err_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.rd       = rd_q;
  assign bus.addr     = addr_q;
  assign bus.ds       = ds_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.beats_ok = bok_q;
endmodule
